// File: rtl/hand_rx_pkg.sv
// Shared types and helpers for the 4-phase handshake receiver and its synchroniser.
package hand_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  function automatic int level_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_par_err(input logic data_xor, input logic par);
    return ~(data_xor ^ par);
  endfunction

endpackage

// File: rtl/hand_sync.sv
// Reset-to-0 flop chain for bringing an asynchronous level into the local clock domain.
module hand_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/hand_rx_buf.sv
// 4-phase req/ack receiver with a DEPTH-entry buffer and valid/ready output.
// Optional macro HAND_RX_BUF_PARITY_EN adds rx_par_in / out_perr with per-entry parity flags.
//
// state | meaning
// IDLE  | ack low, capture on synchronised req when the buffer has room
// ACK   | ack high, waiting for synchronised req to return low
module hand_rx_buf
  import hand_rx_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int DEPTH       = 4,
  localparam int LW          = level_width(DEPTH)
) (
  input  logic              rx_clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [DATA_W-1:0] rx_data_in,
`ifdef HAND_RX_BUF_PARITY_EN
  input  logic              rx_par_in,
  output logic              out_perr,
`endif
  output logic              ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     level
);

  localparam int             PW       = ptr_width(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_req_s;
  logic              w_full;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_mem [DEPTH];

  hand_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (rx_clk),
    .reset_n (reset_n),
    .d       (req),
    .q       (w_req_s)
  );

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_s && !w_full) w_state_nxt = ACK;
      ACK:     if (!w_req_s)           w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // Full uses registered level, so a same-cycle pop never frees the slot for a capture.
  always_comb begin
    w_full  = (r_level == FULL_LVL);
    w_wr_en = (r_state == IDLE) && w_req_s && !w_full;
    w_rd_en = (r_level != '0) && out_ready;
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= rx_data_in;
    end
  end

`ifdef HAND_RX_BUF_PARITY_EN
  logic r_perr [DEPTH];

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_perr[i] <= 1'b0;
    end else if (w_wr_en) begin
      r_perr[r_wr_ptr] <= odd_par_err(^rx_data_in, rx_par_in);
    end
  end

  assign out_perr = r_perr[r_rd_ptr];
`endif

  assign ack       = (r_state == ACK);
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_level != '0);
  assign level     = r_level;

endmodule

// File: tb/tb_hand_rx_buf.sv
// Directed and randomised bench for hand_rx_buf against a queue-based buffer model.
module tb_hand_rx_buf;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int LAT    = SYNC + 1;
  localparam int BUDGET = 40;

  logic              rx_clk = 1'b0;
  logic              reset_n;
  logic              req;
  logic [DATA_W-1:0] rx_data_in;
  logic              ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
`ifdef HAND_RX_BUF_PARITY_EN
  logic              rx_par_in;
  logic              out_perr;
  logic              pq[$];
`endif

  int                n_assert = 0;
  int                n_fail   = 0;
  int                max_lvl  = 0;
  bit                rand_rdy = 1'b0;
  logic [DATA_W-1:0] q[$];

  hand_rx_buf #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .DEPTH       (DEPTH)
  ) dut (
    .rx_clk     (rx_clk),
    .reset_n    (reset_n),
    .req        (req),
    .rx_data_in (rx_data_in),
`ifdef HAND_RX_BUF_PARITY_EN
    .rx_par_in  (rx_par_in),
    .out_perr   (out_perr),
`endif
    .ack        (ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply the model's pop/push rules, then compare the buffer view.
  task automatic step();
    logic pop;
    logic prev_ack;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    pop      = out_ready && (q.size() > 0);
    prev_ack = ack;
    @(posedge rx_clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
`ifdef HAND_RX_BUF_PARITY_EN
      void'(pq.pop_front());
`endif
    end
    if (ack === 1'b1 && prev_ack === 1'b0) begin
      q.push_back(rx_data_in);
`ifdef HAND_RX_BUF_PARITY_EN
      pq.push_back((^rx_data_in ^ rx_par_in) == 1'b0);
`endif
    end
    if (q.size() > max_lvl) max_lvl = q.size();
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", 32'(out_data), 32'(q[0]));
`ifdef HAND_RX_BUF_PARITY_EN
    if (pq.size() != 0) chk("head_perr", 32'(out_perr), 32'(pq[0]));
`endif
  endtask

  // Full 4-phase transfer; exp_lat > 0 also checks both edge latencies.
  task automatic xfer(input logic [DATA_W-1:0] d, input int exp_lat, input int gap);
    int n;
    rx_data_in = d;
    req        = 1'b1;
    n          = 0;
    while (ack !== 1'b1 && n < BUDGET) begin step(); n++; end
    if (exp_lat > 0) chk("ack_rise_lat", 32'(n), 32'(exp_lat));
    else             chk("ack_rise_timeout", 32'(n < BUDGET), 32'd1);
    req = 1'b0;
    n   = 0;
    while (ack !== 1'b0 && n < BUDGET) begin step(); n++; end
    if (exp_lat > 0) chk("ack_fall_lat", 32'(n), 32'(exp_lat));
    else             chk("ack_fall_timeout", 32'(n < BUDGET), 32'd1);
    repeat (gap) step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 3) step();
    chk("drain_level", 32'(level), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    req        = 1'b0;
    out_ready  = 1'b0;
    rx_data_in = '0;
`ifdef HAND_RX_BUF_PARITY_EN
    rx_par_in  = 1'b0;
`endif
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(negedge rx_clk);
    reset_n = 1'b1;

    // Single transfer
    xfer(8'hA5, LAT, 2);
    chk("single_head", 32'(out_data), 32'hA5);
    chk("single_level", 32'(level), 32'd1);
    drain();

    // Fill to full, then stall
    for (int i = 1; i <= DEPTH; i++) xfer(8'(i), LAT, 1);
    rx_data_in = 8'h05;
    req        = 1'b1;
    repeat (8) step();
    chk("stall_ack", 32'(ack), 32'd0);
    chk("stall_level", 32'(level), 32'(DEPTH));
    out_ready = 1'b1;
    step();
    chk("pop_no_capture_ack", 32'(ack), 32'd0);
    chk("pop_level", 32'(level), 32'(DEPTH - 1));
    out_ready = 1'b0;
    step();
    chk("late_capture_ack", 32'(ack), 32'd1);
    chk("late_capture_level", 32'(level), 32'(DEPTH));
    chk("late_capture_head", 32'(out_data), 32'h02);
    req = 1'b0;
    n   = 0;
    while (ack !== 1'b0 && n < BUDGET) begin step(); n++; end
    chk("late_ack_fall", 32'(n), 32'(LAT));
    drain();

    // Drain order and pointer wrap with a ready consumer
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) xfer(8'(8'h10 + i), LAT, $urandom_range(0, 4));
    repeat (3) step();
    chk("empty_ready_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Simultaneous read and write
    xfer(8'h21, LAT, 1);
    xfer(8'h22, LAT, 1);
    rx_data_in = 8'h23;
    req        = 1'b1;
    step();
    step();
    chk("simul_pre_ack", 32'(ack), 32'd0);
    out_ready = 1'b1;
    step();
    chk("simul_ack", 32'(ack), 32'd1);
    chk("simul_level", 32'(level), 32'd2);
    chk("simul_head", 32'(out_data), 32'h22);
    out_ready = 1'b0;
    req       = 1'b0;
    n         = 0;
    while (ack !== 1'b0 && n < BUDGET) begin step(); n++; end
    chk("simul_ack_fall", 32'(n), 32'(LAT));
    drain();

    // Random traffic with a random consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) xfer(8'($urandom), 0, $urandom_range(0, 3));
    rand_rdy = 1'b0;
    drain();
    chk("max_level", 32'(max_lvl <= DEPTH), 32'd1);

    // Reset in the middle of a handshake
    xfer(8'h31, LAT, 1);
    xfer(8'h32, LAT, 1);
    rx_data_in = 8'h33;
    req        = 1'b1;
    n          = 0;
    while (ack !== 1'b1 && n < BUDGET) begin step(); n++; end
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    q.delete();
`ifdef HAND_RX_BUF_PARITY_EN
    pq.delete();
`endif
    repeat (2) @(posedge rx_clk);
    @(negedge rx_clk);
    reset_n = 1'b1;
    n       = 0;
    while (ack !== 1'b1 && n < BUDGET) begin step(); n++; end
    chk("post_rst_lat", 32'(n), 32'(LAT));
    chk("post_rst_head", 32'(out_data), 32'h33);
    req = 1'b0;
    n   = 0;
    while (ack !== 1'b0 && n < BUDGET) begin step(); n++; end
    drain();

`ifdef HAND_RX_BUF_PARITY_EN
    rx_par_in = 1'b1;
    xfer(8'h03, LAT, 1);
    chk("par_ok", 32'(out_perr), 32'd0);
    rx_par_in = 1'b0;
    xfer(8'h03, LAT, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("par_err", 32'(out_perr), 32'd1);
    chk("par_err_data", 32'(out_data), 32'h03);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
